sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_pkg.sv | 22 ++
 rtl/sync_fifo_mem.sv | 39 +++
 rtl/sync_fifo.sv | 98 +++++++++
 tb/tb_sync_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared constants and helpers for the synchronous FIFO.
//   - DEFAULT_WIDTH / DEFAULT_DEPTH : default parameter values.
//   - addr_width(depth)             : ceil(log2(depth)), used to size the
//                                     storage address and the pointers.
package sync_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Smallest w with (1 << w) >= depth. Bounded loop so it stays a plain
  // constant function for elaboration.
  function automatic int addr_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem
//   Simple dual-port RAM: one write port, one synchronous read port.
//   Ports:
//     clk      - clock, rising edge
//     rstn     - async active-low reset; clears only the read data register
//     wr_en    - write strobe; wr_data stored at wr_addr
//     wr_addr  - write address
//     wr_data  - write data
//     rd_en    - read strobe; mem[rd_addr] loaded into rd_data
//     rd_addr  - read address
//     rd_data  - registered read data, holds when rd_en is low
//   The array itself is not reset; words are undefined until written.
module sync_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock first-in first-out buffer with registered read data.
//   Ports:
//     clk      - clock, all state changes on rising edge
//     rstn     - async active-low reset: pointers cleared, data_out=0,
//                empty=1, full=0
//     data_in  - write data, captured when a write is accepted
//     w_en     - write request
//     r_en     - read request
//     data_out - read data, updated one edge after an accepted read,
//                otherwise holds
//     empty    - FIFO holds 0 words
//     full     - FIFO holds DEPTH words
//     count    - occupancy 0..DEPTH (only with SYNC_FIFO_COUNT_EN defined)
//   Optional feature macro: SYNC_FIFO_COUNT_EN.
//
//   Handshake: a write is accepted on a rising edge iff w_en=1 and full=0;
//   a read is accepted iff r_en=1 and empty=0. Rejected requests have no
//   effect, so w_en/r_en may be held without harm. Flags depend only on
//   registered pointers, never combinationally on w_en/r_en.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         w_en,
  input  logic                         r_en,
  output logic [WIDTH-1:0]             data_out,
  output logic                         empty,
`ifdef SYNC_FIFO_COUNT_EN
  output logic                         full,
  output logic [addr_width(DEPTH):0]   count
`else
  output logic                         full
`endif
);

  localparam int AW = addr_width(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // One extra MSB beyond the address: equal pointers mean empty, equal
  // address bits with differing MSBs mean the writer lapped the reader.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_acc;
  logic        rd_acc;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

`ifdef SYNC_FIFO_COUNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + PTR_ONE;
        2'b01:   count <= count - PTR_ONE;
        default: count <= count;
      endcase
    end
  end
`endif

  // Read address never equals the write address on an accepted read unless
  // the FIFO is full, and then the write is rejected, so no collision.
  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  logic       clk;
  logic       rstn;
  logic [7:0] data_in;
  logic       w_en;
  logic       r_en;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
`ifdef SYNC_FIFO_COUNT_EN
  logic [4:0] count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_fifo dut (
    .clk      (clk),
    .rstn     (rstn),
    .data_in  (data_in),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_out (data_out),
    .empty    (empty),
`ifdef SYNC_FIFO_COUNT_EN
    .full     (full),
    .count    (count)
`else
    .full     (full)
`endif
  );

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, let one rising edge pass, and
  // return at the next falling edge where outputs are settled.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    w_en    = w;
    r_en    = r;
    data_in = d;
    @(negedge clk);
    w_en    = 1'b0;
    r_en    = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
    #40;
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 8'(i));
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL basic_not_empty got=%b exp=0", empty); end
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++; if (data_out !== 8'(i)) begin failures++; $display("FAIL basic_read%0d got=%h exp=%h", i, data_out, 8'(i)); end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", empty); end
    step(1'b0, 1'b0, 8'hEE);
    checks++; if (data_out !== 8'h05) begin failures++; $display("FAIL basic_hold got=%h exp=05", data_out); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, 8'(8'h10 + i));
      if (i == 14) begin
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_early got=%b exp=0", full); end
      end
      if (i == 15) begin
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_at16 got=%b exp=1", full); end
      end
    end
    checks++; if (full !== 1'b1 || empty !== 1'b0) begin failures++; $display("FAIL full_after17 got=%b%b exp=10", full, empty); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++; if (data_out !== 8'(8'h10 + i)) begin failures++; $display("FAIL full_read%0d got=%h exp=%h", i, data_out, 8'(8'h10 + i)); end
      if (i == 0) begin
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_clear got=%b exp=0", full); end
      end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_drained got=%b exp=1", empty); end
    step(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h1F) begin failures++; $display("FAIL full_extra_read got=%h exp=1f", data_out); end
  endtask

  task automatic test_read_empty();
    step(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h1F || empty !== 1'b1) begin failures++; $display("FAIL empty_read got=%h/%b exp=1f/1", data_out, empty); end
    step(1'b1, 1'b0, 8'hA5);
    step(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL empty_pair got=%h exp=a5", data_out); end
    // Simultaneous request while empty: only the write is taken.
    step(1'b1, 1'b1, 8'h3C);
    checks++; if (data_out !== 8'hA5 || empty !== 1'b0) begin failures++; $display("FAIL empty_simul got=%h/%b exp=a5/0", data_out, empty); end
    step(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h3C || empty !== 1'b1) begin failures++; $display("FAIL empty_simul_read got=%h/%b exp=3c/1", data_out, empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    v = 8'h00;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++) begin
        step(1'b1, 1'b0, v);
        exp_q.push_back(v);
        v = v + 8'h01;
      end
      checks++; if (empty !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL wrap_flags_w%0d got=%b%b exp=00", r, empty, full); end
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 1'b1, 8'h00);
        exp = exp_q.pop_front();
        checks++; if (data_out !== exp) begin failures++; $display("FAIL wrap_r%0d_%0d got=%h exp=%h", r, i, data_out, exp); end
      end
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL wrap_flags_r%0d got=%b%b exp=10", r, empty, full); end
    end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(8'hC0 + i));
      exp_q.push_back(8'(8'hC0 + i));
    end
    // Simultaneous request while full: only the read is taken.
    step(1'b1, 1'b1, 8'hFF);
    exp = exp_q.pop_front();
    checks++; if (data_out !== exp || full !== 1'b0) begin failures++; $display("FAIL simul_full got=%h/%b exp=%h/0", data_out, full, exp); end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 8'h00);
      exp = exp_q.pop_front();
      checks++; if (data_out !== exp) begin failures++; $display("FAIL simul_full_drain%0d got=%h exp=%h", i, data_out, exp); end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL simul_full_empty got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'(8'h80 + i));
      exp_q.push_back(8'(8'h80 + i));
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(8'h88 + i));
      exp_q.push_back(8'(8'h88 + i));
      exp = exp_q.pop_front();
      checks++; if (data_out !== exp || empty !== 1'b0 || full !== 1'b0) begin
        failures++; $display("FAIL b2b_%0d got=%h/%b%b exp=%h/00", i, data_out, empty, full, exp);
      end
    end
    checks++; if (exp_q.size() != 8) begin failures++; $display("FAIL b2b_occupancy got=%0d exp=8", exp_q.size()); end
    // Reset in the middle of a streaming cycle, between clock edges.
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h55;
    #2 rstn = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
      failures++; $display("FAIL midreset got=%b%b/%h exp=10/00", empty, full, data_out);
    end
    exp_q.delete();
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0;
    rstn = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    checks++; if (empty !== 1'b1 || data_out !== 8'h00) begin failures++; $display("FAIL post_reset_read got=%b/%h exp=1/00", empty, data_out); end
    step(1'b1, 1'b0, 8'h6D);
    step(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h6D || empty !== 1'b1) begin failures++; $display("FAIL post_reset_pair got=%h/%b exp=6d/1", data_out, empty); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_full();
    test_read_empty();
    test_wrap();
    test_simul_full();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
